uart_rx: RTL

- UART receiver, downstream of the UART transmitter. Consumes its serial `tx` line and delivers bytes to the core.
- Frame format: 1 start bit, 8 data bits LSB-first, optional parity bit, 1 stop bit.
- Uses a 16x oversampling tick from the shared baud generator. Samples each bit at mid-point.
- Reports parity and framing errors per byte.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types, constants and helpers.
// Used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  localparam int OS_RATE    = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;

  // Parity bit for a data word: even parity is the XOR of
  // the data, odd parity is its inverse.
  function automatic logic parity_calc(
    input logic [DATA_BITS-1:0] data,
    input logic                 odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for an asynchronous input.
// Resets to 1 so an idle serial line looks idle at once.
module sync_ff #(
  parameter int sync_stages = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [sync_stages-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[sync_stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[sync_stages-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling,
// optional parity, per-byte parity and framing errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter bit parity_en   = 1'b1,
  parameter bit parity_odd  = 1'b0,
  parameter int sync_stages = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       os_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  logic rx_s;

  sync_ff #(
    .sync_stages(sync_stages)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  rx_state_t state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;

  logic mid_tick;
  logic bit_tick;

  assign mid_tick = os_tick &&
                    (tick_q == 4'(MID_SAMPLE));
  assign bit_tick = os_tick &&
                    (tick_q == 4'(OS_RATE - 1));

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;

    if (os_tick) begin
      tick_d = tick_q + 4'd1;
    end

    unique case (state_q)
      RX_IDLE: begin
        // Counter stays parked so START begins at 0 even
        // when the edge and an os_tick coincide.
        tick_d = '0;
        if (!rx_s) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (mid_tick) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_tick) begin
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_d = parity_en ? RX_PARITY
                                : RX_STOP;
          end
        end
      end
      RX_PARITY: begin
        if (bit_tick) begin
          par_d   = rx_s;
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bit_tick) begin
          data_d  = shift_q;
          perr_d  = parity_en &&
                    (par_q != parity_calc(shift_q,
                                          parity_odd));
          ferr_d  = !rx_s;
          valid_d = 1'b1;
          state_d = rx_s ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        // A held-low line must go high before a new frame.
        if (rx_s) begin
          state_d = RX_IDLE;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign rx_busy    = (state_q != RX_IDLE);

endmodule
